// File: rtl/router_fsm_np_pkg.sv
// Router control FSM shared types: state encoding and per-state control decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package router_fsm_np_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDR        = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        CHECK_PARITY_ERROR = 4'd4,
        FIFO_FULL_STATE    = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PKT           = 4'd8
    } state_e;

    typedef struct packed {
        logic busy;
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic drop_state;
    } ctrl_t;

    // Moore control word for a state; DROP_PKT absorbs bytes without writing.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            DECODE_ADDR:        c.detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                c.busy      = 1'b1;
                c.lfd_state = 1'b1;
            end
            LOAD_DATA: begin
                c.ld_state      = 1'b1;
                c.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                c.busy          = 1'b1;
                c.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                c.busy        = 1'b1;
                c.rst_int_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                c.busy       = 1'b1;
                c.full_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                c.busy          = 1'b1;
                c.laf_state     = 1'b1;
                c.write_enb_reg = 1'b1;
            end
            WAIT_TILL_EMPTY:    c.busy       = 1'b1;
            DROP_PKT:           c.drop_state = 1'b1;
            default:            c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/router_fsm_np_wait_timer.sv
// Saturating wait counter with synchronous clear; expired flags the last allowed cycle.
// Latency: expired_o is combinational from the count register.
// Backpressure: none; holds at all-ones when enabled past its range.
module router_fsm_np_wait_timer #(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A zero timeout means wait forever.
    assign expired_o = (WAIT_TIMEOUT != 0) && (cnt_q == CW'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM: steers one packet stream to one of N_PORTS FIFOs, drops bad/timed-out packets.
// Latency: outputs registered, valid the cycle after the deciding edge.
// Backpressure: fifo_full stalls into FIFO_FULL_STATE; busy tells the source to hold.
module router_fsm_np
    import router_fsm_np_pkg::*;
#(
    parameter int N_PORTS      = 3,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pkt_valid,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               parity_done,
    input  logic               low_pkt_valid,
    input  logic               fifo_full,
    input  logic [N_PORTS-1:0] fifo_empty,
    input  logic [N_PORTS-1:0] sft_rst,
    output logic [N_PORTS-1:0] dest_sel,
    output logic               busy,
    output logic               detect_add,
    output logic               lfd_state,
    output logic               ld_state,
    output logic               laf_state,
    output logic               full_state,
    output logic               write_enb_reg,
    output logic               rst_int_reg,
    output logic               drop_state,
    output logic               timeout_evt
);

    function automatic logic [N_PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] a);
        logic [N_PORTS-1:0] oh;
        for (int i = 0; i < N_PORTS; i++) begin
            oh[i] = (32'(a) == i);
        end
        return oh;
    endfunction

    state_e             state_q, state_d;
    ctrl_t              ctrl_q;
    logic [N_PORTS-1:0] dest_q, dest_d;
    logic               tevt_q, tevt_d;

    logic [ADDR_W-1:0]  hdr_addr;
    logic [N_PORTS-1:0] hdr_oh;
    logic               hdr_ok;
    logic               soft_rst;
    logic               wait_empty;
    logic               wait_clr;
    logic               wait_expired;

    generate
        if (DATA_W > ADDR_W) begin : g_hdr_upper
            logic unused_hdr_bits;
            assign unused_hdr_bits = ^data_in[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_oh   = port_onehot(hdr_addr);
    assign hdr_ok   = (32'(hdr_addr) < N_PORTS);

    // dest_q is the latched one-hot destination, so masking with it picks only our port.
    assign soft_rst   = (state_q != DECODE_ADDR) && (|(sft_rst & dest_q));
    assign wait_empty = |(fifo_empty & dest_q);
    assign wait_clr   = (state_q != WAIT_TILL_EMPTY) || soft_rst;

    router_fsm_np_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (wait_clr),
        .en_i      (state_q == WAIT_TILL_EMPTY),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        tevt_d  = 1'b0;
        case (state_q)
            DECODE_ADDR: begin
                if (pkt_valid) begin
                    if (!hdr_ok) begin
                        state_d = DROP_PKT;
                    end else if (|(fifo_empty & hdr_oh)) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDR;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                // The FIFO draining on the last allowed cycle still wins over the timeout.
                if (wait_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end else if (wait_expired) begin
                    state_d = DROP_PKT;
                    tevt_d  = 1'b1;
                end
            end
            DROP_PKT: begin
                if (!pkt_valid) begin
                    state_d = DECODE_ADDR;
                end
            end
            default:            state_d = DECODE_ADDR;
        endcase

        if (soft_rst) begin
            state_d = DECODE_ADDR;
            tevt_d  = 1'b0;
        end
    end

    always_comb begin
        dest_d = dest_q;
        if (state_d == DECODE_ADDR) begin
            dest_d = '0;
        end else if (state_q == DECODE_ADDR) begin
            dest_d = hdr_oh;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DECODE_ADDR;
            ctrl_q  <= state_ctrl(DECODE_ADDR);
            dest_q  <= '0;
            tevt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
            dest_q  <= dest_d;
            tevt_q  <= tevt_d;
        end
    end

    assign dest_sel      = dest_q;
    assign busy          = ctrl_q.busy;
    assign detect_add    = ctrl_q.detect_add;
    assign lfd_state     = ctrl_q.lfd_state;
    assign ld_state      = ctrl_q.ld_state;
    assign laf_state     = ctrl_q.laf_state;
    assign full_state    = ctrl_q.full_state;
    assign write_enb_reg = ctrl_q.write_enb_reg;
    assign rst_int_reg   = ctrl_q.rst_int_reg;
    assign drop_state    = ctrl_q.drop_state;
    assign timeout_evt   = tevt_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: stimulus pushes expected outputs, a monitor pops and compares.
module tb_router_fsm_np;

    localparam int N = 3;

    // {parity_done, low_pkt_valid, fifo_full}
    localparam logic [2:0] C0  = 3'b000;
    localparam logic [2:0] CFF = 3'b001;
    localparam logic [2:0] CLP = 3'b010;
    localparam logic [2:0] CPD = 3'b100;

    typedef enum int {S_D, S_LFD, S_LD, S_LP, S_CPE, S_FF, S_LAF, S_WT, S_DR} tst_e;

    typedef struct {
        tst_e           st;
        logic [N-1:0]   dest;
        logic           tevt;
        string          nm;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic         parity_done = 1'b0;
    logic         low_pkt_valid = 1'b0;
    logic         fifo_full = 1'b0;
    logic [N-1:0] fifo_empty = '0;
    logic [N-1:0] sft_rst = '0;
    logic [N-1:0] dest_sel;
    logic         busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic         write_enb_reg, rst_int_reg, drop_state, timeout_evt;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    event chk_ev;

    always #5 clk = ~clk;

    router_fsm_np #(
        .N_PORTS      (N),
        .DATA_W       (8),
        .ADDR_W       (2),
        .WAIT_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .sft_rst       (sft_rst),
        .dest_sel      (dest_sel),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .drop_state    (drop_state),
        .timeout_evt   (timeout_evt)
    );

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int, drop}
    function automatic logic [8:0] req_ctl(input tst_e s);
        case (s)
            S_D:     return 9'b010000000;
            S_LFD:   return 9'b101000000;
            S_LD:    return 9'b000100100;
            S_LP:    return 9'b100000100;
            S_CPE:   return 9'b100000010;
            S_FF:    return 9'b100001000;
            S_LAF:   return 9'b100010100;
            S_WT:    return 9'b100000000;
            S_DR:    return 9'b000000001;
            default: return 9'b111111111;
        endcase
    endfunction

    task automatic push(input tst_e st, input logic [N-1:0] dest, input logic tevt, input string nm);
        exp_t e;
        e.st   = st;
        e.dest = dest;
        e.tevt = tevt;
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs; the expectation is the output after the following rising edge.
    task automatic step(input logic pv, input logic [7:0] d, input logic [2:0] ctl,
                        input logic [N-1:0] fe, input logic [N-1:0] sr,
                        input tst_e st, input logic [N-1:0] dest, input logic tevt, input string nm);
        @(negedge clk);
        pkt_valid     = pv;
        data_in       = d;
        parity_done   = ctl[2];
        low_pkt_valid = ctl[1];
        fifo_full     = ctl[0];
        fifo_empty    = fe;
        sft_rst       = sr;
        push(st, dest, tevt, nm);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act_ctl;
        logic [8:0] want_ctl;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                act_ctl  = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                            write_enb_reg, rst_int_reg, drop_state};
                want_ctl = req_ctl(e.st);
                checks++;
                if (act_ctl == want_ctl && dest_sel == e.dest && timeout_evt == e.tevt) begin
                    passed++;
                end else begin
                    $display("FAIL %s @%0t: got ctl=%b dest=%b tevt=%b, want ctl=%b dest=%b tevt=%b",
                             e.nm, $time, act_ctl, dest_sel, timeout_evt, want_ctl, e.dest, e.tevt);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state
        step(0, 8'h00, C0, 3'b000, 3'b000, S_D, 3'b000, 0, "reset0");
        step(0, 8'h00, C0, 3'b000, 3'b000, S_D, 3'b000, 0, "reset1");
        @(negedge clk);
        rstn = 1'b1;

        // 1: addr 2 (upper header bits ignored), five payload bytes, normal parity path
        step(1, 8'hFE, C0, 3'b111, 3'b000, S_LFD, 3'b100, 0, "t1_hdr");
        for (int i = 0; i < 5; i++)
            step(1, 8'(8'h10 + i), C0, 3'b111, 3'b000, S_LD, 3'b100, 0, "t1_ld");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_LP,  3'b100, 0, "t1_lp");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_CPE, 3'b100, 0, "t1_cpe");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_D,   3'b000, 0, "t1_done");

        // 2: addr 3 out of range with 3 ports -> drop, bytes absorbed without writes
        step(1, 8'h07, C0, 3'b111, 3'b000, S_DR, 3'b000, 0, "t2_hdr");
        for (int i = 0; i < 6; i++)
            step(1, 8'h55, C0, 3'b111, 3'b000, S_DR, 3'b000, 0, "t2_absorb");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_D, 3'b000, 0, "t2_done");

        // 3a: addr 1 never drains -> 8 cycles WAIT, one-cycle timeout pulse, drop
        step(1, 8'h01, C0, 3'b101, 3'b000, S_WT, 3'b010, 0, "t3_enter");
        for (int i = 0; i < 7; i++)
            step(1, 8'h00, C0, 3'b101, 3'b000, S_WT, 3'b010, 0, "t3_wait");
        step(1, 8'h00, C0, 3'b101, 3'b000, S_DR, 3'b010, 1, "t3_timeout");
        step(1, 8'h00, C0, 3'b101, 3'b000, S_DR, 3'b010, 0, "t3_pulse_end");
        step(0, 8'h00, C0, 3'b101, 3'b000, S_D,  3'b000, 0, "t3_done");

        // 3b: FIFO drains on the last allowed WAIT cycle -> LFD wins over timeout
        step(1, 8'h01, C0, 3'b101, 3'b000, S_WT, 3'b010, 0, "t3b_enter");
        for (int i = 0; i < 7; i++)
            step(1, 8'h00, C0, 3'b101, 3'b000, S_WT, 3'b010, 0, "t3b_wait");
        step(1, 8'h00, C0, 3'b111, 3'b000, S_LFD, 3'b010, 0, "t3b_late_empty");
        step(1, 8'h00, C0, 3'b111, 3'b000, S_LD,  3'b010, 0, "t3b_ld");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_LP,  3'b010, 0, "t3b_lp");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_CPE, 3'b010, 0, "t3b_cpe");
        step(0, 8'h00, C0, 3'b111, 3'b000, S_D,   3'b000, 0, "t3b_done");

        // 4a: full for 3 cycles in LOAD_DATA, then low_pkt_valid -> LOAD_PARITY
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LFD, 3'b001, 0, "t4_hdr");
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LD,  3'b001, 0, "t4_ld");
        for (int i = 0; i < 3; i++)
            step(1, 8'h00, CFF, 3'b111, 3'b000, S_FF, 3'b001, 0, "t4_full");
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LAF, 3'b001, 0, "t4_laf");
        step(0, 8'h00, CLP, 3'b111, 3'b000, S_LP,  3'b001, 0, "t4_lpv");
        step(0, 8'h00, C0,  3'b111, 3'b000, S_CPE, 3'b001, 0, "t4_cpe");
        step(0, 8'h00, C0,  3'b111, 3'b000, S_D,   3'b000, 0, "t4_done");

        // 4b: LAF back to LD, full again at parity check, parity_done ends packet
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LFD, 3'b001, 0, "t4b_hdr");
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LD,  3'b001, 0, "t4b_ld");
        step(1, 8'h00, CFF, 3'b111, 3'b000, S_FF,  3'b001, 0, "t4b_full");
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LAF, 3'b001, 0, "t4b_laf");
        step(1, 8'h00, C0,  3'b111, 3'b000, S_LD,  3'b001, 0, "t4b_laf_ld");
        step(0, 8'h00, C0,  3'b111, 3'b000, S_LP,  3'b001, 0, "t4b_lp");
        step(0, 8'h00, C0,  3'b111, 3'b000, S_CPE, 3'b001, 0, "t4b_cpe");
        step(0, 8'h00, CFF, 3'b111, 3'b000, S_FF,  3'b001, 0, "t4b_cpe_full");
        step(0, 8'h00, C0,  3'b111, 3'b000, S_LAF, 3'b001, 0, "t4b_laf2");
        step(0, 8'h00, CPD, 3'b111, 3'b000, S_D,   3'b000, 0, "t4b_pdone");

        // 5: soft reset only from the latched destination, ignored when idle
        step(1, 8'h01, C0, 3'b111, 3'b000, S_LFD, 3'b010, 0, "t5_hdr");
        step(1, 8'h00, C0, 3'b111, 3'b000, S_LD,  3'b010, 0, "t5_ld");
        step(1, 8'h00, C0, 3'b111, 3'b100, S_LD,  3'b010, 0, "t5_other_srst");
        step(1, 8'h00, C0, 3'b111, 3'b010, S_D,   3'b000, 0, "t5_own_srst");
        step(0, 8'h00, C0, 3'b111, 3'b010, S_D,   3'b000, 0, "t5_idle_srst");

        // 6: asynchronous reset between edges while waiting
        step(1, 8'h02, C0, 3'b011, 3'b000, S_WT, 3'b100, 0, "t6_enter");
        step(1, 8'h00, C0, 3'b011, 3'b000, S_WT, 3'b100, 0, "t6_wait");
        step(1, 8'h00, C0, 3'b011, 3'b000, S_WT, 3'b100, 0, "t6_wait");
        @(negedge clk);
        #1;
        rstn = 1'b0;
        push(S_D, 3'b000, 0, "t6_async");
        ->chk_ev;
        step(0, 8'h00, C0, 3'b011, 3'b000, S_D, 3'b000, 0, "t6_hold");
        @(negedge clk);
        rstn = 1'b1;
        step(0, 8'h00, C0, 3'b011, 3'b000, S_D, 3'b000, 0, "t6_after");

        repeat (3) @(negedge clk);
        if (passed != checks) begin
            $display("FAIL summary: %0d of %0d checks failed", checks - passed, checks);
        end
        if (exp_q.size() != 0) begin
            $display("FAIL summary: %0d expectations never compared", exp_q.size());
        end
        if (checks < 12) begin
            $display("FAIL summary: only %0d checks ran", checks);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
